audio_tone_wb: RTL and testbench
================================

# audio_tone_wb

Multi-channel audio test-tone generator, the parametrised successor to the fixed single triangle source that drives `spdif_tx`. Holds `NCH` phase accumulators with per-channel step, waveform and attenuation, all programmable over the Wishbone bus from `muacm2wb`. It advances one sample per consumer `out_ack` pulse and presents registered signed samples for `spdif_tx`'s `audio_l`/`audio_r`.

## Interface
- `NCH`, 2, channel count, 1..15.
- `DW`, 16, sample width, signed two's complement, 8..24.
- `PW`, 24, phase accumulator width, `PW >= max(DW,16)`.
- `clk`  in  1  system clock; everything is synchronous to it.
- `rst_n`  in  1  **asynchronous, active-low reset.**
- `wb_addr`  in  4  register index.
- `wb_wdata`  in  32  write data.
- `wb_rdata`  out  32  read data; 0 whenever `wb_ack` is low.
- `wb_we`  in  1  write strobe.
- `wb_cyc`  in  1  cycle request; held high until `wb_ack`.
- `wb_ack`  out  1  single-cycle acknowledge.
- `out_ack`  in  1  one-cycle pulse per consumed sample frame.
- `out_data`  out  NCH*DW  channel c in bits `[c*DW +: DW]`.

## Operation
- Register 0 is GLOBAL:
  - bit0 `EN`, read/write.
  - bit1 `PRST`, write-1 pulse, reads 0.
  - bits[11:8] read `NCH`.
- Register 1+c is CHANNEL c:
  - [15:0] `STEP`.
  - [18:16] `MODE`.
  - [22:20] `ATT`.
  - Read returns the stored fields, other bits 0.
  - An address above NCH reads 0 and ignores writes, but is still acked.
- Wishbone:
  - `wb_ack` is asserted the cycle after `wb_cyc` is first seen high.
  - It is never asserted on two consecutive cycles.
  - Writes commit on the ack cycle.
- Accumulator, per channel on an `out_ack` cycle with `EN=1`: `acc <= acc + zext(STEP)`, mod 2^PW.
- Phase `p` is `acc[PW-1 -: DW]`, unsigned.
- Waveform by `MODE`:
  - 0: silence, 0.
  - 1: saw, `p - 2^(DW-1)`.
  - 2: triangle. `t = p[DW-2:0] ^ {DW-1{p[DW-1]}}`, then `{t,1'b0} - 2^(DW-1)`.
  - 3: square. `p[DW-1]` gives -2^(DW-1), otherwise 2^(DW-1)-1.
  - 4: noise, see Configuration.
  - 5..7: silence.
- Attenuation: arithmetic right shift of the waveform by `ATT` (0..7).
- `EN=0`:
  - Accumulators hold.
  - `out_data` is forced to 0.
  - `out_ack` is ignored.
- `PRST` write: all accumulators go to 0. If it coincides with an `out_ack` advance, the clear wins.
- `STEP` change: used from the next advance.
- `MODE`/`ATT` change: visible on `out_data` one cycle after the write ack.

## Timing
- Reset values:
  - `EN=0`.
  - All channel registers 0.
  - Accumulators 0.
  - `out_data=0`, `wb_ack=0`, `wb_rdata=0`.
  - LFSRs at 16'hACE1.
- `out_ack` sampled at edge k updates the accumulator at k. `out_data` reflects it at edge k+1 (registered output).
- `out_ack` pulses are at least 2 cycles apart. A pulse while `EN=0` is dropped, not queued.
- Wishbone latency: 1 cycle to ack; `wb_rdata` is valid only during ack.
- Asserting `rst_n` mid-transaction aborts it with no ack. All state returns to reset values immediately.

## Configuration
- `AUDIO_TONE_NOISE_EN`:
  - Defined:
    - Each channel has a 16-bit Galois LFSR, taps 16'hB400, seeded 16'hACE1.
    - The LFSR steps on every advance in every mode.
    - `PRST` reseeds it.
    - MODE 4 outputs `{lfsr, {DW{1'b0}}}[DW+15 -: DW]`, attenuated.
  - Undefined: no LFSR logic; MODE 4 is silence.

## Structure
- Package `audio_tone_pkg`:
  - Register index constants (GLOBAL=0, CH_BASE=1).
  - Mode encoding enum.
  - Field bit positions.
  - LFSR taps and seed.
- Sub-module `audio_tone_chan`, instantiated NCH times:
  - Holds accumulator, LFSR, waveform mux, attenuation and output register.
  - The top holds the Wishbone decode and GLOBAL register.

## Test plan
- Reset, then read GLOBAL -> `wb_rdata=32'h0000_0200` (NCH=2); `out_data=0`.
- CH0 = STEP 16'h1000, MODE 1, `EN=1`, 16 `out_ack` pulses -> ch0 sample after pulse n is `n*16 - 32768`, e.g. n=1 gives 16'h8010.
- CH1 = MODE 2, STEP 16'hFFFF, ATT 1 -> samples rise and then fall symmetrically, peak ≤ 16'h3FFF. Wrap past 2^24 gives no discontinuity in the triangle.
- MODE 3 with `out_ack` held off for 100 cycles -> `out_data` constant. Write `PRST` on the same cycle as an `out_ack` -> accumulator reads 0 and the sample is 16'h7FFF.
- `EN=0` mid-stream -> `out_data=0` next cycle. Re-enable -> resumes from the held phase.
- With `AUDIO_TONE_NOISE_EN`, MODE 4 -> first sample 16'hACE1 after one advance-free update, then matches the reference LFSR sequence. Without the macro -> 0.

Source files
------------

// File: rtl/audio_tone_pkg.sv
// Shared constants for the multi-channel test-tone generator: register map,
// waveform mode encoding, field positions and noise LFSR parameters.
package audio_tone_pkg;

    localparam logic [3:0] REG_GLOBAL  = 4'd0;
    localparam logic [3:0] REG_CH_BASE = 4'd1;

    typedef enum logic [2:0] {
        MODE_SILENT = 3'd0,
        MODE_SAW    = 3'd1,
        MODE_TRI    = 3'd2,
        MODE_SQUARE = 3'd3,
        MODE_NOISE  = 3'd4
    } mode_e;

    localparam int GLB_EN_BIT   = 0;
    localparam int GLB_PRST_BIT = 1;
    localparam int CH_STEP_LSB  = 0;
    localparam int CH_MODE_LSB  = 16;
    localparam int CH_ATT_LSB   = 20;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/audio_tone_if.sv
// Wishbone-style register bus between the muacm2wb bridge and the tone generator.
interface audio_tone_if;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic        cyc;
    logic        ack;

    modport master (output addr, wdata, we, cyc, input rdata, ack);
    modport slave  (input addr, wdata, we, cyc, output rdata, ack);
endinterface

// File: rtl/audio_tone_chan.sv
// One tone channel: config fields, phase accumulator, waveform shaping and
// registered sample. Noise LFSR exists only with AUDIO_TONE_NOISE_EN defined.
module audio_tone_chan
    import audio_tone_pkg::*;
#(
    parameter int DW = 16,
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          advance,
    input  logic          prst,
    input  logic          cfg_we,
    input  logic [15:0]   cfg_step,
    input  logic [2:0]    cfg_mode,
    input  logic [2:0]    cfg_att,
    output logic [31:0]   cfg_rdata,
    output logic [DW-1:0] sample
);
    logic [15:0]          step;
    logic [2:0]           mode;
    logic [2:0]           att;
    logic [PW-1:0]        acc;
    logic [DW-1:0]        p;
    logic [DW-1:0]        half;
    logic [DW-2:0]        tri_t;
    logic [DW-1:0]        wave;
    logic signed [DW-1:0] shaped;

    assign half  = {1'b1, {(DW-1){1'b0}}};
    assign p     = acc[PW-1 -: DW];
    assign tri_t = p[DW-2:0] ^ {(DW-1){p[DW-1]}};

`ifdef AUDIO_TONE_NOISE_EN
    logic [15:0]    lfsr;
    logic [DW+15:0] noise_word;

    assign noise_word = {lfsr, {DW{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lfsr <= LFSR_SEED;
        else if (prst)    lfsr <= LFSR_SEED;
        else if (advance) lfsr <= lfsr_next(lfsr);
    end
`endif

    always_comb begin
        wave = '0;
        case (mode)
            MODE_SAW:    wave = p - half;
            MODE_TRI:    wave = {tri_t, 1'b0} - half;
            MODE_SQUARE: wave = p[DW-1] ? half : ~half;
`ifdef AUDIO_TONE_NOISE_EN
            MODE_NOISE:  wave = noise_word[DW+15 -: DW];
`endif
            default:     wave = '0;
        endcase
    end

    assign shaped    = $signed(wave) >>> att;
    assign cfg_rdata = {9'b0, att, 1'b0, mode, step};

    // A phase reset on the same edge as an advance leaves the accumulator at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= '0;
            mode   <= '0;
            att    <= '0;
            acc    <= '0;
            sample <= '0;
        end else begin
            if (cfg_we) begin
                step <= cfg_step;
                mode <= cfg_mode;
                att  <= cfg_att;
            end
            if (prst)         acc <= '0;
            else if (advance) acc <= acc + PW'(step);
            sample <= en ? shaped : '0;
        end
    end

endmodule

// File: rtl/audio_tone_wb.sv
// Multi-channel test-tone generator top: register decode, GLOBAL register and
// NCH channel instances. Build with AUDIO_TONE_NOISE_EN for LFSR noise in MODE 4.
module audio_tone_wb
    import audio_tone_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DW  = 16,
    parameter int PW  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    audio_tone_if.slave       wb,
    input  logic              out_ack,
    output logic [NCH*DW-1:0] out_data
);
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic        en;
    logic        wr;
    logic        prst;
    logic        advance;
    logic [31:0] ch_rdata [NCH];
    logic        unused_wdata;

    assign wr           = wb.cyc && ack_q && wb.we;
    assign prst         = wr && (wb.addr == REG_GLOBAL) && wb.wdata[GLB_PRST_BIT];
    assign advance      = out_ack && en;
    assign unused_wdata = ^{wb.wdata[31:23], wb.wdata[19]};

    always_comb begin
        rd_mux = '0;
        if (wb.addr == REG_GLOBAL)
            rd_mux = {20'h0, 4'(NCH), 6'h0, 1'b0, en};
        for (int c = 0; c < NCH; c++)
            if (wb.addr == 4'(c + 1))
                rd_mux = ch_rdata[c];
    end

    // Ack follows the first cycle cyc is seen and drops for one cycle after,
    // so back-to-back requests never see ack on consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            en      <= 1'b0;
        end else begin
            ack_q   <= wb.cyc && !ack_q;
            rdata_q <= (wb.cyc && !ack_q) ? rd_mux : '0;
            if (wr && (wb.addr == REG_GLOBAL))
                en <= wb.wdata[GLB_EN_BIT];
        end
    end

    assign wb.ack   = ack_q;
    assign wb.rdata = rdata_q;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        audio_tone_chan #(.DW(DW), .PW(PW)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .advance   (advance),
            .prst      (prst),
            .cfg_we    (wr && (wb.addr == 4'(REG_CH_BASE + c))),
            .cfg_step  (wb.wdata[CH_STEP_LSB +: 16]),
            .cfg_mode  (wb.wdata[CH_MODE_LSB +: 3]),
            .cfg_att   (wb.wdata[CH_ATT_LSB +: 3]),
            .cfg_rdata (ch_rdata[c]),
            .sample    (out_data[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_audio_tone_wb.sv
// Scoreboard bench for audio_tone_wb: stimulus pushes expected read data and
// sample frames; a monitor pops and compares when the DUT presents them.
module tb_audio_tone_wb;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int PW  = 24;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              out_ack = 1'b0;
    logic              probe   = 1'b0;
    logic [NCH*DW-1:0] out_data;

    audio_tone_if wb ();

    audio_tone_wb #(.NCH(NCH), .DW(DW), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb       (wb),
        .out_ack  (out_ack),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t frame_q[$];
    exp_t rd_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    // A strobe (out_ack or probe) at edge k means out_data is due after edge k+1.
    always @(posedge clk) begin
        s1 <= out_ack | probe;
        s2 <= s1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (s2) begin
            checks++;
            if (frame_q.size() == 0) begin
                failures++;
                $display("FAIL frame_unexpected got=%h exp=none", out_data);
            end else begin
                e = frame_q.pop_front();
                if (out_data !== e.data) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", e.name, out_data, e.data);
                end
            end
        end
        if (wb.ack && !wb.we) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected got=%h exp=none", wb.rdata);
            end else begin
                e = rd_q.pop_front();
                if (wb.rdata !== e.data) begin
                    failures++;
                    $display("FAIL %s got=%h exp=%h", e.name, wb.rdata, e.data);
                end
            end
        end
    end

    task automatic wb_xfer(input logic [3:0] a, input logic [31:0] d, input logic we, input bit with_ack);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        wb.addr = a; wb.wdata = d; wb.we = we; wb.cyc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb.ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wb_timeout addr=%0d got=no_ack exp=ack", a);
        end
        if (with_ack) out_ack = 1'b1;
        @(posedge clk); #1;
        wb.cyc = 1'b0; wb.we = 1'b0; out_ack = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        wb_xfer(a, d, 1'b1, 1'b0);
    endtask

    task automatic wb_read(input logic [3:0] a, input logic [31:0] exp_d, input string name);
        rd_q.push_back('{exp_d, name});
        wb_xfer(a, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic [31:0] exp_d, input string name);
        frame_q.push_back('{exp_d, name});
        @(posedge clk); #1 out_ack = 1'b1;
        @(posedge clk); #1 out_ack = 1'b0;
    endtask

    task automatic probe_chk(input logic [31:0] exp_d, input string name);
        frame_q.push_back('{exp_d, name});
        @(posedge clk); #1 probe = 1'b1;
        @(posedge clk); #1 probe = 1'b0;
    endtask

    // Triangle reference as a folded ramp on the 16-bit phase, then attenuation.
    function automatic logic [15:0] tri_ref(input longint acc, input int att);
        int p;
        int v;
        p = int'((acc >> 8) & 64'hFFFF);
        if (p < 32768) v = 2 * p - 32768;
        else           v = 2 * (65535 - p) - 32768;
        v = v >>> att;
        return 16'(v);
    endfunction

    function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    initial begin
        longint      acc;
        logic [15:0] sq;
        logic [15:0] lf;

        wb.addr = '0; wb.wdata = '0; wb.we = 1'b0; wb.cyc = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wb.ack !== 1'b0 || wb.rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got=ack%b/rdata%h exp=ack0/rdata00000000", wb.ack, wb.rdata);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        probe_chk(32'h0, "reset_out");
        wb_read(4'd0, 32'h0000_0200, "global_reset");
        wb_read(4'd1, 32'h0, "ch0_reset");
        wb_write(4'd5, 32'hFFFF_FFFF);
        wb_read(4'd5, 32'h0, "addr_above_nch");
        wb_read(4'd3, 32'h0, "addr3_above_nch");

        wb_write(4'd1, 32'h0001_1000);
        wb_read(4'd1, 32'h0001_1000, "ch0_readback");
        wb_write(4'd2, 32'hFFFF_FFFF);
        wb_read(4'd2, 32'h0077_FFFF, "ch1_readback_fields");
        wb_write(4'd2, 32'h0);
        wb_write(4'd0, 32'h1);
        wb_read(4'd0, 32'h0000_0201, "global_en");

        // Saw on ch0: sample after pulse n is n*16 - 32768.
        pulse(32'h0000_8010, "saw_n1");
        for (int n = 2; n <= 16; n++)
            pulse({16'h0, 16'(n * 16 - 32768)}, "saw_ramp");

        // Triangle on ch1 with ATT 1 through a full 2^24 wrap.
        wb_write(4'd1, 32'h0);
        wb_write(4'd2, 32'h0012_FFFF);
        pulse(32'hC0FF_0000, "tri_n1");
        pulse(32'hC1FF_0000, "tri_n2");
        acc = 64'h1FFFE;
        for (int n = 3; n <= 260; n++) begin
            acc = (acc + 64'hFFFF) & 64'hFF_FFFF;
            pulse({tri_ref(acc, 1), 16'h0}, "tri_model");
        end
        wb_write(4'd2, 32'h0);

        // Phase reset coinciding with an advance: clear wins.
        wb_write(4'd1, 32'h0001_1000);
        probe_chk(32'h0000_8100, "saw_held");
        frame_q.push_back('{32'h0000_8000, "prst_vs_advance"});
        wb_xfer(4'd0, 32'h3, 1'b1, 1'b1);
        pulse(32'h0000_8010, "after_prst");

        wb_write(4'd1, 32'h0003_1000);
        probe_chk(32'h0000_7FFF, "square_mode_change");
        for (int i = 0; i < 4; i++) begin
            repeat (25) @(posedge clk);
            probe_chk(32'h0000_7FFF, "square_hold");
        end
        frame_q.push_back('{32'h0000_7FFF, "prst_square"});
        wb_xfer(4'd0, 32'h3, 1'b1, 1'b1);

        wb_write(4'd1, 32'h0003_FFFF);
        acc = 0;
        for (int n = 1; n <= 130; n++) begin
            acc = (acc + 64'hFFFF) & 64'hFF_FFFF;
            sq  = acc[23] ? 16'h8000 : 16'h7FFF;
            pulse({16'h0, sq}, "square_model");
        end

        // Disable mid-stream, pulse is dropped, re-enable resumes held phase.
        wb_write(4'd1, 32'h0001_1000);
        probe_chk(32'h0000_01FF, "saw_at_81FF");
        wb_write(4'd0, 32'h0);
        probe_chk(32'h0, "en_off_zero");
        pulse(32'h0, "pulse_dropped");
        wb_write(4'd0, 32'h1);
        probe_chk(32'h0000_01FF, "resume_held");
        pulse(32'h0000_020F, "resume_advance");

        wb_write(4'd1, 32'h0033_1000);
        probe_chk(32'h0000_F000, "att3_square");
        wb_read(4'd1, 32'h0033_1000, "ch0_att_readback");

        // Noise mode after reseed.
        wb_write(4'd1, 32'h0004_1000);
        wb_write(4'd0, 32'h3);
`ifdef AUDIO_TONE_NOISE_EN
        lf = 16'hACE1;
        probe_chk({16'h0, lf}, "noise_seed");
        for (int n = 0; n < 4; n++) begin
            lf = lfsr_ref(lf);
            pulse({16'h0, lf}, "noise_seq");
        end
`else
        lf = 16'h0;
        probe_chk({16'h0, lf}, "noise_absent");
        pulse({16'h0, lf}, "noise_absent_adv");
`endif

        // Reset asserted mid-write: no ack, state back to reset values.
        @(posedge clk); #1;
        wb.addr = 4'd1; wb.wdata = 32'h0001_1234; wb.we = 1'b1; wb.cyc = 1'b1;
        #3 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wb.ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_ack got=%b exp=0", wb.ack);
        end
        @(posedge clk); #1;
        wb.cyc = 1'b0; wb.we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wb_read(4'd0, 32'h0000_0200, "global_after_abort");
        wb_read(4'd1, 32'h0, "ch0_after_abort");
        probe_chk(32'h0, "out_after_abort");

        repeat (4) @(posedge clk);
        checks++;
        if (frame_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained got=%0d/%0d exp=0/0", frame_q.size(), rd_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
